gpr_writeback: RTL and testbench

//  Writeback stage directly upstream of the GPR bank. Merges ALU results and out-of-order memory

---
 rtl/gpr_writeback_pkg.sv | 41 ++++
 rtl/gpr_writeback_phys_map.sv | 15 +
 rtl/gpr_writeback.sv | 146 ++++++++++++++
 tb/tb_gpr_writeback.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_writeback_pkg.sv
// Shared definitions for the GPR writeback stage: id groups, physical
// index layout of the load scoreboard and the id -> physical map.
package gpr_writeback_pkg;

    localparam logic [6:0] NULL_ID   = 7'h7F;
    localparam logic [3:0] GRP_LO    = 4'h0;
    localparam logic [3:0] GRP_HI    = 4'h1;
    localparam logic [3:0] GRP_ALT   = 4'h4;
    localparam int         SR_RB_BIT = 29;
    localparam int         PHYS_W    = 5;
    localparam int         SB_W      = 24;

    typedef struct packed {
        logic              valid;
        logic [PHYS_W-1:0] idx;
    } phys_t;

    // Group is id[6:3], register within the group is id[2:0].
    // Physical 0-7 / 8-15 hold the two banked sets, 16-23 the unbanked set.
    function automatic phys_t mapId(input logic [6:0] id, input logic rb);
        phys_t p;
        p = '0;
        case (id[6:3])
            GRP_LO: begin
                p.valid = 1'b1;
                p.idx   = {1'b0, rb, id[2:0]};
            end
            GRP_ALT: begin
                p.valid = 1'b1;
                p.idx   = {1'b0, ~rb, id[2:0]};
            end
            GRP_HI: begin
                p.valid = 1'b1;
                p.idx   = {2'b10, id[2:0]};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/gpr_writeback_phys_map.sv
// Combinational register id + SR.RB -> {valid, physical index}.
module gpr_phys_map
    import gpr_writeback_pkg::*;
(
    input  logic [6:0] idRn,
    input  logic       rb,
    output phys_t      phys
);

    // Pure lookup; invalid groups come back with valid=0
    always_comb begin
        phys = mapId(idRn, rb);
    end

endmodule

// File: rtl/gpr_writeback.sv
// Writeback stage feeding the GPR bank write port: ALU results win over
// queued load returns, and a load scoreboard drives the decode stall.
module gpr_writeback #(
    parameter int         LDQ_DEPTH = 2,
    parameter logic [6:0] NULL_ID   = gpr_writeback_pkg::NULL_ID
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] regSrVal,
    input  logic        exValid,
    input  logic [6:0]  exIdRn,
    input  logic [31:0] exVal,
    input  logic        ldIssue,
    input  logic [6:0]  ldIdRn,
    input  logic        memValid,
    input  logic [6:0]  memIdRn,
    input  logic [31:0] memVal,
    output logic        memReady,
    input  logic [6:0]  regIdRs,
    input  logic [6:0]  regIdRt,
    input  logic [6:0]  regIdRm,
    output logic        srcStall,
    output logic        ldPending,
    output logic [6:0]  regIdRn,
    output logic [31:0] regValRn
);
    import gpr_writeback_pkg::*;

    localparam int PTR_W = $clog2(LDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             rb;
    logic             unusedSrBits;
    logic [6:0]       qId  [LDQ_DEPTH];
    logic [31:0]      qVal [LDQ_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [SB_W-1:0]  busy;
    logic [SB_W-1:0]  setVec;
    logic [SB_W-1:0]  clrVec;
    logic             push;
    logic             pop;
    logic [6:0]       headId;
    logic [31:0]      headVal;
    logic [6:0]       srcId   [3];
    phys_t            srcPhys [3];
    phys_t            ldPhys;
    phys_t            headPhys;

    assign rb           = regSrVal[SR_RB_BIT];
    assign unusedSrBits = ^{regSrVal[31:SR_RB_BIT+1], regSrVal[SR_RB_BIT-1:0]};

    assign memReady  = (count != CNT_W'(LDQ_DEPTH));
    assign push      = memValid && memReady;
    // The head only reaches the port when the ALU leaves it free
    assign pop       = !exValid && (count != '0);
    assign headId    = qId[rdPtr];
    assign headVal   = qVal[rdPtr];
    assign ldPending = |busy;

    assign srcId[0] = regIdRs;
    assign srcId[1] = regIdRt;
    assign srcId[2] = regIdRm;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gSrcMap
            gpr_phys_map uSrcMap (.idRn(srcId[gi]), .rb(rb), .phys(srcPhys[gi]));
        end
    endgenerate

    gpr_phys_map uLdMap   (.idRn(ldIdRn), .rb(rb), .phys(ldPhys));
    gpr_phys_map uHeadMap (.idRn(headId), .rb(rb), .phys(headPhys));

    // A busy bit drops when its load is driven onto the port, not at queue push
    assign setVec = (ldIssue && ldPhys.valid) ? (SB_W'(1) << ldPhys.idx) : '0;
    assign clrVec = (pop && headPhys.valid) ? (SB_W'(1) << headPhys.idx) : '0;

    // Stall decode while any valid source register still waits on a load
    always_comb begin
        srcStall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (srcPhys[k].valid && busy[srcPhys[k].idx]) begin
                srcStall = 1'b1;
            end
        end
    end

    // Queue payload storage; contents are meaningless outside count
    always_ff @(posedge clock) begin
        if (push) begin
            qId[wrPtr]  <= memIdRn;
            qVal[wrPtr] <= memVal;
        end
    end

    // Queue pointers, occupancy and scoreboard (set wins over clear)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            busy  <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            busy <= (busy & ~clrVec) | setVec;
        end
    end

    // Bank write port: ALU first, then queue head, else idle id
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regIdRn  <= NULL_ID;
            regValRn <= '0;
        end else if (exValid) begin
            regIdRn  <= exIdRn;
            regValRn <= exVal;
        end else if (pop) begin
            regIdRn  <= headId;
            regValRn <= headVal;
        end else begin
            regIdRn  <= NULL_ID;
            regValRn <= '0;
        end
    end

    // Upstream contract checks
    phys_t exPhysChk;
    phys_t memPhysChk;
    assign exPhysChk  = mapId(exIdRn, rb);
    assign memPhysChk = mapId(memIdRn, rb);

    aExNotBusy: assert property (@(posedge clock) disable iff (!reset)
        exValid |-> !(exPhysChk.valid && busy[exPhysChk.idx]));
    aRbStable: assert property (@(posedge clock) disable iff (!reset)
        ldPending |-> $stable(rb));
    aMemKnown: assert property (@(posedge clock) disable iff (!reset)
        (memValid && memReady) |-> (memPhysChk.valid && busy[memPhysChk.idx]));

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback with a queue/array reference model.
module tb_gpr_writeback;

    localparam int         DEPTH  = 2;
    localparam logic [6:0] NULLID = 7'h7F;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] regSrVal = '0;
    logic        exValid = 1'b0;
    logic [6:0]  exIdRn = '0;
    logic [31:0] exVal = '0;
    logic        ldIssue = 1'b0;
    logic [6:0]  ldIdRn = '0;
    logic        memValid = 1'b0;
    logic [6:0]  memIdRn = '0;
    logic [31:0] memVal = '0;
    logic        memReady;
    logic [6:0]  regIdRs = '0;
    logic [6:0]  regIdRt = '0;
    logic [6:0]  regIdRm = '0;
    logic        srcStall;
    logic        ldPending;
    logic [6:0]  regIdRn;
    logic [31:0] regValRn;

    int checks = 0;
    int errors = 0;

    gpr_writeback #(.LDQ_DEPTH(DEPTH), .NULL_ID(NULLID)) dut (
        .clock(clock), .reset(reset), .regSrVal(regSrVal),
        .exValid(exValid), .exIdRn(exIdRn), .exVal(exVal),
        .ldIssue(ldIssue), .ldIdRn(ldIdRn),
        .memValid(memValid), .memIdRn(memIdRn), .memVal(memVal), .memReady(memReady),
        .regIdRs(regIdRs), .regIdRt(regIdRt), .regIdRm(regIdRm),
        .srcStall(srcStall), .ldPending(ldPending),
        .regIdRn(regIdRn), .regValRn(regValRn)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [6:0]  id;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    bit          mBusy [24];
    logic [6:0]  mId  = NULLID;
    logic [31:0] mVal = '0;
    bit          mAcc;
    int          mP;
    ent_t        mE;
    bit          cStall;
    bit          cPend;

    function automatic int phys(input logic [6:0] id, input logic rb);
        int g;
        int i;
        g = int'(id) / 8;
        i = int'(id) % 8;
        if (g == 0) return rb ? 8 + i : i;
        if (g == 4) return rb ? i : 8 + i;
        if (g == 1) return 16 + i;
        return -1;
    endfunction

    function automatic bit busyAt(input logic [6:0] id);
        int p;
        p = phys(id, regSrVal[29]);
        return (p >= 0) && mBusy[p];
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            for (int k = 0; k < 24; k++) mBusy[k] = 1'b0;
            mId  = NULLID;
            mVal = '0;
        end else begin
            mAcc = memValid && (mq.size() < DEPTH);
            if (exValid) begin
                mId  = exIdRn;
                mVal = exVal;
            end else if (mq.size() > 0) begin
                mE   = mq.pop_front();
                mId  = mE.id;
                mVal = mE.val;
                mP   = phys(mE.id, regSrVal[29]);
                if (mP >= 0) mBusy[mP] = 1'b0;
            end else begin
                mId  = NULLID;
                mVal = '0;
            end
            if (mAcc) mq.push_back({memIdRn, memVal});
            if (ldIssue) begin
                mP = phys(ldIdRn, regSrVal[29]);
                if (mP >= 0) mBusy[mP] = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        cStall = busyAt(regIdRs) || busyAt(regIdRt) || busyAt(regIdRm);
        cPend  = 1'b0;
        for (int k = 0; k < 24; k++) if (mBusy[k]) cPend = 1'b1;
        chk("m_regIdRn", regIdRn, mId);
        chk("m_regValRn", regValRn, mVal);
        chk("m_memReady", memReady, (mq.size() < DEPTH));
        chk("m_srcStall", srcStall, cStall);
        chk("m_ldPending", ldPending, cPend);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_id", regIdRn, NULLID);
        chk("rst_val", regValRn, 32'h0);
        chk("rst_ready", memReady, 1'b1);
        chk("rst_stall", srcStall, 1'b0);
        chk("rst_pend", ldPending, 1'b0);
        step();
        reset = 1'b1;
        step();

        // 1: ALU write, one-cycle latency, then idle
        exValid = 1'b1; exIdRn = 7'h03; exVal = 32'hDEADBEEF;
        step();
        exValid = 1'b0;
        @(negedge clock);
        chk("t1_id", regIdRn, 7'h03);
        chk("t1_val", regValRn, 32'hDEADBEEF);
        step();
        @(negedge clock);
        chk("t1_null", regIdRn, NULLID);

        // 2: load issue marks busy
        step();
        ldIssue = 1'b1; ldIdRn = 7'h0A;
        step();
        ldIssue = 1'b0; regIdRs = 7'h0A;
        @(negedge clock);
        chk("t2_stall", srcStall, 1'b1);
        chk("t2_pend", ldPending, 1'b1);
        step(); step();
        @(negedge clock);
        chk("t2_stall_hold", srcStall, 1'b1);

        // 3: return collides with ALU write
        step();
        memValid = 1'b1; memIdRn = 7'h0A; memVal = 32'h12345678;
        exValid = 1'b1; exIdRn = 7'h01; exVal = 32'hA5A5A5A5;
        step();
        memValid = 1'b0; exValid = 1'b0;
        @(negedge clock);
        chk("t3_c1_id", regIdRn, 7'h01);
        chk("t3_c1_stall", srcStall, 1'b1);
        step();
        @(negedge clock);
        chk("t3_c2_id", regIdRn, 7'h0A);
        chk("t3_c2_val", regValRn, 32'h12345678);
        chk("t3_c2_stall", srcStall, 1'b0);
        chk("t3_c2_pend", ldPending, 1'b0);
        regIdRs = 7'h00;

        // 4: queue fills behind a held ALU stream
        step();
        ldIssue = 1'b1; ldIdRn = 7'h09; step();
        ldIdRn = 7'h0B; step();
        ldIdRn = 7'h0C; step();
        ldIssue = 1'b0;
        exValid = 1'b1; exIdRn = 7'h04; exVal = 32'd1000;
        memValid = 1'b1; memIdRn = 7'h09; memVal = 32'h9009;
        @(negedge clock); chk("t4_rdy0", memReady, 1'b1); step();
        exIdRn = 7'h05; exVal = 32'd1001; memIdRn = 7'h0B; memVal = 32'hB00B;
        @(negedge clock); chk("t4_rdy1", memReady, 1'b1); step();
        exIdRn = 7'h06; exVal = 32'd1002; memIdRn = 7'h0C; memVal = 32'hC00C;
        @(negedge clock); chk("t4_rdy2", memReady, 1'b0); step();
        exIdRn = 7'h07; exVal = 32'd1003;
        @(negedge clock); chk("t4_rdy3", memReady, 1'b0); step();
        exValid = 1'b0;
        @(negedge clock);
        chk("t4_rdy4", memReady, 1'b0);
        chk("t4_id4", regIdRn, 7'h07);
        step();
        @(negedge clock);
        chk("t4_rdy5", memReady, 1'b1);
        chk("t4_id5", regIdRn, 7'h09);
        chk("t4_val5", regValRn, 32'h9009);
        step();
        memValid = 1'b0;
        @(negedge clock);
        chk("t4_id6", regIdRn, 7'h0B);
        chk("t4_val6", regValRn, 32'hB00B);
        step();
        @(negedge clock);
        chk("t4_id7", regIdRn, 7'h0C);
        chk("t4_val7", regValRn, 32'hC00C);
        chk("t4_pend7", ldPending, 1'b0);
        step();

        // 5: RB=1, alternate-bank id 7'h22 lands on physical 2
        regSrVal = 32'h2000_0000;
        step(); step();
        ldIssue = 1'b1; ldIdRn = 7'h22;
        step();
        ldIssue = 1'b0; regIdRs = 7'h02;
        @(negedge clock);
        chk("t5_rs02", srcStall, 1'b0);
        chk("t5_pend", ldPending, 1'b1);
        #1 regIdRs = 7'h22;
        #1 chk("t5_rs22", srcStall, 1'b1);
        #1 regIdRs = 7'h00; regIdRt = 7'h22;
        #1 chk("t5_rt22", srcStall, 1'b1);
        #1 regIdRt = 7'h00; regIdRm = 7'h22;
        #1 chk("t5_rm22", srcStall, 1'b1);
        step();
        memValid = 1'b1; memIdRn = 7'h22; memVal = 32'h2222;
        step();
        memValid = 1'b0;
        @(negedge clock);
        chk("t5_queued_stall", srcStall, 1'b1);
        step();
        @(negedge clock);
        chk("t5_id", regIdRn, 7'h22);
        chk("t5_drain_stall", srcStall, 1'b0);
        regIdRm = 7'h00;
        step();
        regSrVal = 32'h0;
        step(); step();

        // 6: asynchronous reset with a full queue
        ldIssue = 1'b1; ldIdRn = 7'h03; step();
        ldIdRn = 7'h05; step();
        ldIssue = 1'b0;
        exValid = 1'b1; exIdRn = 7'h11; exVal = 32'h11;
        memValid = 1'b1; memIdRn = 7'h03; memVal = 32'h3;
        step();
        memIdRn = 7'h05; memVal = 32'h5; exIdRn = 7'h12; exVal = 32'h12;
        step();
        memValid = 1'b0; regIdRs = 7'h03;
        @(negedge clock);
        chk("t6_full_rdy", memReady, 1'b0);
        chk("t6_pre_stall", srcStall, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("t6_id", regIdRn, NULLID);
        chk("t6_val", regValRn, 32'h0);
        chk("t6_rdy", memReady, 1'b1);
        chk("t6_stall", srcStall, 1'b0);
        chk("t6_pend", ldPending, 1'b0);
        exValid = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        @(negedge clock);
        chk("t6_after_id", regIdRn, NULLID);
        chk("t6_after_rdy", memReady, 1'b1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
